// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter for the HPS SDRAM Avalon-MM port.
// Read returns are routed back to their issuer through an ID FIFO.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 29,
    parameter int DATA_W   = 64,
    parameter int MAX_PEND = 8
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,

    input  logic [ADDR_W-1:0]           m0_address,
    input  logic                        m0_read,
    input  logic                        m0_write,
    input  logic [DATA_W-1:0]           m0_writedata,
    input  logic [DATA_W/8-1:0]         m0_byteenable,
    output logic                        m0_waitrequest,
    output logic [DATA_W-1:0]           m0_readdata,
    output logic                        m0_readdatavalid,

    input  logic [ADDR_W-1:0]           m1_address,
    input  logic                        m1_read,
    input  logic                        m1_write,
    input  logic [DATA_W-1:0]           m1_writedata,
    input  logic [DATA_W/8-1:0]         m1_byteenable,
    output logic                        m1_waitrequest,
    output logic [DATA_W-1:0]           m1_readdata,
    output logic                        m1_readdatavalid,

    output logic [ADDR_W-1:0]           s_address,
    output logic                        s_read,
    output logic                        s_write,
    output logic [DATA_W-1:0]           s_writedata,
    output logic [DATA_W/8-1:0]         s_byteenable,
    input  logic                        s_waitrequest,
    input  logic [DATA_W-1:0]           s_readdata,
    input  logic                        s_readdatavalid,

    output logic [$clog2(MAX_PEND):0]   pending_count,
    output logic                        err_unexpected_rdv
);

    localparam int PW = $clog2(MAX_PEND);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            owner;
    logic            owner_nx;
    logic            last_grant;
    logic            last_nx;

    logic [MAX_PEND-1:0] id_mem;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            err;

    logic            req0;
    logic            req1;
    logic            o_read;
    logic            o_write;
    logic            o_wait;
    logic            fifo_full;
    logic            fifo_nonempty;
    logic            push;
    logic            pop;
    logic            head;

    assign req0          = m0_read | m0_write;
    assign req1          = m1_read | m1_write;
    assign o_read        = owner ? m1_read  : m0_read;
    assign o_write       = owner ? m1_write : m0_write;
    assign fifo_full     = (count == CW'(MAX_PEND));
    assign fifo_nonempty = (count != '0);
    assign head          = id_mem[rptr];

    // The data path always follows the owner; only the strobes gate it.
    assign s_address    = owner ? m1_address    : m0_address;
    assign s_writedata  = owner ? m1_writedata  : m0_writedata;
    assign s_byteenable = owner ? m1_byteenable : m0_byteenable;

    assign push = s_read & ~s_waitrequest;
    assign pop  = s_readdatavalid & fifo_nonempty;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop & head;

    assign pending_count      = count;
    assign err_unexpected_rdv = err;

    // Grant selection, command forwarding and waitrequest steering.
    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        last_nx        = last_grant;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        o_wait         = 1'b1;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_nx = OWN;
                    owner_nx = (req0 & req1) ? ~last_grant : req1;
                end
            end
            OWN: begin
                // A read into a full FIFO is held off the port.
                s_read  = o_read & ~fifo_full;
                s_write = o_write;
                o_wait  = (o_read & fifo_full) | s_waitrequest;
                if (owner) begin
                    m1_waitrequest = o_wait;
                end else begin
                    m0_waitrequest = o_wait;
                end
                if ((s_read | s_write) & ~s_waitrequest) begin
                    state_nx = IDLE;
                    last_nx  = owner;
                end
            end
        endcase
    end

    // Arbiter state; last_grant starts at 1 so m0 wins the first tie.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_nx;
        end
    end

    // Read-ID FIFO; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            id_mem <= '0;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_mem[wptr] <= owner;
                wptr         <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a return beat with nothing outstanding.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            err <= 1'b0;
        end else if (s_readdatavalid & ~fifo_nonempty) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: queue-based reference model checked
// every cycle, directed scenarios with literal values, random traffic.
module tb_sdram_port_arbiter;

    localparam int ADDR_W   = 29;
    localparam int DATA_W   = 64;
    localparam int MAX_PEND = 8;
    localparam int CW       = $clog2(MAX_PEND) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [7:0]        m0_byteenable, m1_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic              s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [7:0]        s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic [CW-1:0]     pending_count;
    logic              err_unexpected_rdv;

    int checks   = 0;
    int failures = 0;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .m0_address(m0_address), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .pending_count(pending_count),
        .err_unexpected_rdv(err_unexpected_rdv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int          q[$];
    int          own;
    int          last;
    bit          merr;
    logic        rq[2], wq[2], e_w[2], e_rdv[2];
    logic [63:0] ad[2], wd[2], bq[2];
    logic        e_sr, e_sw, full, pop_now, set_err;

    initial begin
        own = -1; last = 1; merr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete(); own = -1; last = 1; merr = 0;
                chk("rst_m0_wait", 64'(m0_waitrequest), 64'(1));
                chk("rst_m1_wait", 64'(m1_waitrequest), 64'(1));
                chk("rst_s_read", 64'(s_read), 64'(0));
                chk("rst_s_write", 64'(s_write), 64'(0));
                chk("rst_m0_rdv", 64'(m0_readdatavalid), 64'(0));
                chk("rst_m1_rdv", 64'(m1_readdatavalid), 64'(0));
                chk("rst_pending", 64'(pending_count), 64'(0));
                chk("rst_err", 64'(err_unexpected_rdv), 64'(0));
            end else begin
                rq[0] = m0_read;  wq[0] = m0_write;
                rq[1] = m1_read;  wq[1] = m1_write;
                ad[0] = 64'(m0_address); ad[1] = 64'(m1_address);
                wd[0] = m0_writedata;    wd[1] = m1_writedata;
                bq[0] = 64'(m0_byteenable); bq[1] = 64'(m1_byteenable);
                e_sr = 0; e_sw = 0; e_w[0] = 1; e_w[1] = 1;
                e_rdv[0] = 0; e_rdv[1] = 0; pop_now = 0; set_err = 0;
                full = (q.size() == MAX_PEND);
                if (own >= 0) begin
                    e_sr = rq[own] && !full;
                    e_sw = wq[own];
                    e_w[own] = (rq[own] && full) ? 1'b1 : s_waitrequest;
                end
                if (s_readdatavalid) begin
                    if (q.size() != 0) begin
                        e_rdv[q[0]] = 1; pop_now = 1;
                    end else begin
                        set_err = 1;
                    end
                end
                chk("m0_wait", 64'(m0_waitrequest), 64'(e_w[0]));
                chk("m1_wait", 64'(m1_waitrequest), 64'(e_w[1]));
                chk("s_read", 64'(s_read), 64'(e_sr));
                chk("s_write", 64'(s_write), 64'(e_sw));
                if (e_sr || e_sw) begin
                    chk("s_address", 64'(s_address), ad[own]);
                    chk("s_byteenable", 64'(s_byteenable), bq[own]);
                    if (e_sw) chk("s_writedata", s_writedata, wd[own]);
                end
                chk("m0_rdv", 64'(m0_readdatavalid), 64'(e_rdv[0]));
                chk("m1_rdv", 64'(m1_readdatavalid), 64'(e_rdv[1]));
                chk("m0_rdata", m0_readdata, s_readdata);
                chk("m1_rdata", m1_readdata, s_readdata);
                chk("pending", 64'(pending_count), 64'(q.size()));
                chk("err", 64'(err_unexpected_rdv), 64'(merr));
                if (pop_now) void'(q.pop_front());
                if (e_sr && !s_waitrequest) q.push_back(own);
                if (set_err) merr = 1;
                if (own < 0) begin
                    if ((rq[0] | wq[0]) && (rq[1] | wq[1])) own = 1 - last;
                    else if (rq[0] | wq[0]) own = 0;
                    else if (rq[1] | wq[1]) own = 1;
                end else if ((e_sr || e_sw) && !s_waitrequest) begin
                    last = own;
                    own = -1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0;
        m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0;
        m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic new_cmd(output logic rd, output logic wr,
                           output logic [ADDR_W-1:0] a,
                           output logic [DATA_W-1:0] d,
                           output logic [7:0] b);
        rd = 1'($urandom_range(1));
        wr = !rd;
        a  = ADDR_W'($urandom);
        d  = {$urandom, $urandom};
        b  = 8'($urandom);
    endtask

    logic acc0, acc1;

    initial begin
        clear_inputs();
        rst_n = 0;
        tick(); tick();
        @(negedge clk);
        chk("lit_rst_wait", 64'(m0_waitrequest), 64'(1));
        tick();
        rst_n = 1;

        // single write
        m0_write = 1; m0_address = 29'h100;
        m0_writedata = 64'hA5A5A5A5A5A5A5A5; m0_byteenable = 8'hFF;
        @(negedge clk);
        chk("lit_wr_idle", 64'(s_write), 64'(0));
        tick();
        @(negedge clk);
        chk("lit_wr_cmd", 64'(s_write), 64'(1));
        chk("lit_wr_addr", 64'(s_address), 64'h100);
        chk("lit_wr_m0_wait", 64'(m0_waitrequest), 64'(0));
        chk("lit_wr_m1_wait", 64'(m1_waitrequest), 64'(1));
        tick();
        m0_write = 0;
        @(negedge clk);
        chk("lit_wr_once", 64'(s_write), 64'(0));
        tick();

        // tie after reset: m0, m1, m0, m1
        do_reset();
        m0_read = 1; m0_address = 29'h200;
        m1_read = 1; m1_address = 29'h300;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lit_tie_pend", 64'(pending_count), 64'(i / 2));
            if (i % 2 == 1) begin
                chk("lit_tie_rd", 64'(s_read), 64'(1));
                chk("lit_tie_gnt", ((i / 2) % 2 == 0) ?
                    64'(m0_waitrequest) : 64'(m1_waitrequest), 64'(0));
            end else begin
                chk("lit_tie_idle", 64'(s_read), 64'(0));
            end
            tick();
        end
        m0_read = 0; m1_read = 0;
        @(negedge clk);
        chk("lit_tie_pend4", 64'(pending_count), 64'(4));
        tick();

        // read routing: queue holds m0, m1, m0, m1
        for (int k = 0; k < 4; k++) begin
            s_readdatavalid = 1;
            s_readdata = 64'(8'h11 * (k + 1));
            @(negedge clk);
            chk("lit_route_m0", 64'(m0_readdatavalid), 64'(k % 2 == 0));
            chk("lit_route_m1", 64'(m1_readdatavalid), 64'(k % 2 == 1));
            chk("lit_route_data", m0_readdata, 64'(8'h11 * (k + 1)));
            tick();
        end
        s_readdatavalid = 0;
        @(negedge clk);
        chk("lit_route_pend0", 64'(pending_count), 64'(0));
        tick();

        // FIFO full
        m0_read = 1; m0_address = 29'h400;
        repeat (16) tick();
        @(negedge clk);
        chk("lit_full_pend8", 64'(pending_count), 64'(8));
        tick();
        m1_write = 1; m1_address = 29'h500;
        m1_writedata = 64'h0123456789ABCDEF; m1_byteenable = 8'h0F;
        @(negedge clk);
        chk("lit_full_hold_rd", 64'(s_read), 64'(0));
        chk("lit_full_hold_w", 64'(m0_waitrequest), 64'(1));
        tick();
        s_readdatavalid = 1; s_readdata = 64'h77;
        @(negedge clk);
        chk("lit_full_hold_rd2", 64'(s_read), 64'(0));
        chk("lit_full_ret", 64'(m0_readdatavalid), 64'(1));
        tick();
        s_readdatavalid = 0;
        @(negedge clk);
        chk("lit_full_rel_rd", 64'(s_read), 64'(1));
        chk("lit_full_rel_w", 64'(m0_waitrequest), 64'(0));
        chk("lit_full_pend7", 64'(pending_count), 64'(7));
        tick();
        m0_read = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("lit_full_wr", 64'(s_write), 64'(1));
        chk("lit_full_wr_w", 64'(m1_waitrequest), 64'(0));
        chk("lit_full_wr_a", 64'(s_address), 64'h500);
        tick();
        m1_write = 0;

        // simultaneous push and pop at pending 3
        do_reset();
        m1_read = 1; m1_address = 29'h600;
        repeat (6) tick();
        m1_read = 0;
        m0_read = 1; m0_address = 29'h700;
        @(negedge clk);
        chk("lit_pp_pend3", 64'(pending_count), 64'(3));
        tick();
        s_readdatavalid = 1; s_readdata = 64'h33;
        @(negedge clk);
        chk("lit_pp_rd", 64'(s_read), 64'(1));
        chk("lit_pp_m1", 64'(m1_readdatavalid), 64'(1));
        chk("lit_pp_m0", 64'(m0_readdatavalid), 64'(0));
        tick();
        m0_read = 0; s_readdatavalid = 0;
        @(negedge clk);
        chk("lit_pp_stay3", 64'(pending_count), 64'(3));
        tick();
        for (int k = 0; k < 3; k++) begin
            s_readdatavalid = 1;
            @(negedge clk);
            chk("lit_pp_drain", 64'(m0_readdatavalid), 64'(k == 2));
            tick();
        end
        s_readdatavalid = 0;

        // unexpected return
        s_readdatavalid = 1; s_readdata = 64'h99;
        @(negedge clk);
        chk("lit_err_m0", 64'(m0_readdatavalid), 64'(0));
        chk("lit_err_m1", 64'(m1_readdatavalid), 64'(0));
        chk("lit_err_pre", 64'(err_unexpected_rdv), 64'(0));
        tick();
        s_readdatavalid = 0;
        @(negedge clk);
        chk("lit_err_set", 64'(err_unexpected_rdv), 64'(1));
        tick();

        // mid-operation reset
        m1_read = 1; m1_address = 29'h800;
        tick(); tick();
        m1_read = 0;
        m0_read = 1; m0_address = 29'h900; s_waitrequest = 1;
        tick();
        @(negedge clk);
        chk("lit_mr_stall", 64'(s_read), 64'(1));
        chk("lit_mr_pend1", 64'(pending_count), 64'(1));
        tick();
        rst_n = 0;
        @(negedge clk);
        chk("lit_mr_rd", 64'(s_read), 64'(0));
        chk("lit_mr_w", 64'(m0_waitrequest), 64'(1));
        chk("lit_mr_err", 64'(err_unexpected_rdv), 64'(0));
        tick();
        m0_read = 0; s_waitrequest = 0;
        rst_n = 1;
        s_readdatavalid = 1;
        @(negedge clk);
        chk("lit_mr_rdv", 64'(m0_readdatavalid), 64'(0));
        tick();
        s_readdatavalid = 0;
        @(negedge clk);
        chk("lit_mr_err1", 64'(err_unexpected_rdv), 64'(1));
        tick();

        // random traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            acc0 = (m0_read | m0_write) & ~m0_waitrequest;
            acc1 = (m1_read | m1_write) & ~m1_waitrequest;
            tick();
            if (acc0) begin m0_read = 0; m0_write = 0; end
            if (acc1) begin m1_read = 0; m1_write = 0; end
            if (!(m0_read | m0_write) && $urandom_range(1) == 0)
                new_cmd(m0_read, m0_write, m0_address,
                        m0_writedata, m0_byteenable);
            if (!(m1_read | m1_write) && $urandom_range(1) == 0)
                new_cmd(m1_read, m1_write, m1_address,
                        m1_writedata, m1_byteenable);
            s_waitrequest = ($urandom_range(3) == 0);
            s_readdatavalid = (n < 2000) ? ($urandom_range(7) == 0)
                                         : ($urandom_range(1) == 0);
            s_readdata = {$urandom, $urandom};
        end
        clear_inputs();
        @(negedge clk);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-master round-robin arbiter that shares the single FPGA-to-HPS SDRAM Avalon-MM port of the DDR3 memory subsystem between two FPGA-fabric requesters. It serialises single-word read/write commands onto the port and tracks outstanding reads so that each `readdatavalid` beat is routed back to the master that issued the read. It sits between the fabric masters and the HPS SDRAM bridge.

## Interface
Parameters:
- `ADDR_W`, 29: word address width, common to both masters and the slave port.
- `DATA_W`, 64: data width; the byte-enable width is `DATA_W/8`.
- `MAX_PEND`, 8: maximum number of outstanding reads; a power of two, at least 2.

Ports (mN = m0, m1):
- `clk_clk`  in  1  sole clock; all logic is on its rising edge.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `mN_address`  in  ADDR_W  master word address.
- `mN_read`, `mN_write`  in  1  command strobes. Asserting both at once is illegal.
- `mN_writedata`  in  DATA_W; `mN_byteenable`  in  DATA_W/8.
- `mN_waitrequest`  out  1  command stall to the master.
- `mN_readdata`  out  DATA_W  read data to the master, valid only with `mN_readdatavalid`.
- `mN_readdatavalid`  out  1  read data valid to the master.
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`  out  command to the SDRAM port.
- `s_waitrequest`  in  1  stall from the SDRAM port.
- `s_readdata`  in  DATA_W; `s_readdatavalid`  in  1  read return from the SDRAM port; returns arrive in order.
- `pending_count`  out  $clog2(MAX_PEND)+1  number of outstanding reads.
- `err_unexpected_rdv`  out  1  sticky flag for a read return with no outstanding read.

## Operation
- **State machine**
  - IDLE: no command is driven. If m0 or m1 requests (read|write), go to OWN with `owner` set to the winner.
  - Winner selection: if only one master requests, it wins. If both request, the master not granted last time wins.
  - OWN: the owner's address, strobes, data and byte-enables are forwarded to `s_*`.
  - OWN exits to IDLE on the cycle the command is accepted, i.e. `(s_read|s_write) & !s_waitrequest`. `last_grant` is updated to `owner` on that cycle.
- **Waitrequest**
  - The non-owner, and both masters while in IDLE, see `mN_waitrequest=1`.
  - The owner sees `s_waitrequest`, except when it issues a read while the read FIFO is full. In that case `s_read` is forced to 0 and the owner sees waitrequest=1.
  - Writes are never blocked by FIFO occupancy.
- **Read-ID FIFO** (depth MAX_PEND, 1-bit entries holding the issuing master ID)
  - Push: on an accepted read.
  - Pop: on `s_readdatavalid`.
  - `mN_readdatavalid = s_readdatavalid & fifo_nonempty & (head == N)`.
  - `s_readdata` is broadcast to both `mN_readdata`.
  - Simultaneous push and pop: occupancy is unchanged and both the write and read pointers advance. The pointers wrap modulo MAX_PEND.
  - `s_readdatavalid` with the FIFO empty: the beat is dropped, nothing is popped, and `err_unexpected_rdv` is set. The flag clears only on reset.
- **Reset values**
  - State IDLE, `last_grant`=1 so that m0 wins the first tie.
  - FIFO empty, `pending_count`=0.
  - `s_read`=`s_write`=0.
  - `mN_waitrequest`=1, `mN_readdatavalid`=0, `err_unexpected_rdv`=0.
- **Reset mid-operation**: all state clears immediately. Outstanding reads are forgotten, so any return arriving after reset raises `err_unexpected_rdv`.
- A master that deasserts its request while it is owner violates Avalon; no recovery is specified.

## Timing
- Request to `s_*` command: the request is seen in IDLE in cycle T, and the command is driven from cycle T+1.
- The slave path is forwarded combinationally from registered `owner`. With `s_waitrequest`=0 the command is accepted in T+1.
- Peak throughput is one command per 2 cycles, because every acceptance returns to IDLE for one cycle.
- `s_readdatavalid` to `mN_readdatavalid`: 0 cycles (combinational).
- `pending_count` updates on the clock edge after a push or pop.
- Outputs driven combinationally from inputs are `mN_waitrequest`, `mN_readdatavalid` and the `s_*` command; all other state is registered.

## Test plan
- **Single write**: m0 writes addr 0x100, data 0xA5A5…, `s_waitrequest`=0.
  - `s_write` is high for exactly 1 cycle, at T+1, with addr 0x100.
  - `m0_waitrequest` is low in that cycle.
  - m1 waitrequest stays high throughout.
- **Tie after reset**: both masters request reads continuously.
  - Slave sees the order m0, m1, m0, m1, with one IDLE cycle between commands.
  - `pending_count` climbs 0→1→2…
- **Read routing**: m0 reads A, then m1 reads B. Return two beats with data 0x11, then 0x22.
  - `m0_readdatavalid` fires with 0x11, then `m1_readdatavalid` fires with 0x22.
  - `pending_count` returns to 0.
- **FIFO full**: with MAX_PEND=8, issue 8 reads with no returns, then a 9th read followed by a write from the other master.
  - The 9th read is held: waitrequest=1 and `s_read`=0.
  - The write is accepted.
  - One return releases the 9th read on the following OWN cycle.
- **Simultaneous push and pop**: at `pending_count`=3, accept a read in the same cycle that `s_readdatavalid`=1.
  - Count stays at 3, and the returned beat routes to the oldest ID.
- **Error and reset**: pulse `s_readdatavalid` with the FIFO empty.
  - `err_unexpected_rdv`=1 from the next edge, and both `mN_readdatavalid` stay 0.
- **Mid-operation reset**: assert `reset_reset_n`=0 mid-transaction.
  - All outputs take their reset values within the same cycle.
  - `err_unexpected_rdv` clears.
